// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial master/slave bus: responder FSM state codes and frame mode bits.
package serial_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t ADDR  = 3'd1;
  localparam state_t WDATA = 3'd2;
  localparam state_t WRITE = 3'd3;
  localparam state_t RREQ  = 3'd4;
  localparam state_t RWAIT = 3'd5;
  localparam state_t RDATA = 3'd6;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB and leave from bit 0; clear beats load beats shift.
// Updates on the enabled edge only; no flow control of its own.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      q <= '0;
    else if (clr)   q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {sin, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/serial_slave_if.sv
// Serial bus responder: deserializes address/write data, performs one parallel access, serializes read data back.
// mem_wen the cycle after the last write bit; svalid 2 cycles after mem_ren; SSIF_TIMEOUT_EN enables stalled-frame abort.
module serial_slave_if
  import serial_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int RXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW  = $clog2(RXW) + 1;

  state_t          state, state_nxt;
  logic            mode;
  logic [CW-1:0]   cnt;
  logic [RXW-1:0]  rx_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic            rx_shift, addr_last, wdat_last, rd_last, timeout;
  logic            unused_rx, unused_tx;

  assign rx_shift  = mvalid && (state == IDLE || state == ADDR || state == WDATA);
  assign addr_last = (state == ADDR)  && mvalid && (cnt == CW'(ADDR_WIDTH - 1));
  assign wdat_last = (state == WDATA) && mvalid && (cnt == CW'(DATA_WIDTH - 1));
  assign rd_last   = (state == RDATA) && (cnt == CW'(DATA_WIDTH - 1));

`ifdef SSIF_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      gap_cnt <= '0;
    else if ((state == ADDR || state == WDATA) && !mvalid)
      gap_cnt <= gap_cnt + 1'b1;
    else
      gap_cnt <= '0;
  end

  assign timeout = (state == ADDR || state == WDATA) && !mvalid &&
                   (gap_cnt == GW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mvalid) state_nxt = ADDR;
      ADDR:    if (timeout) state_nxt = IDLE;
               else if (addr_last) state_nxt = (mode == MODE_WRITE) ? WDATA : RREQ;
      WDATA:   if (timeout) state_nxt = IDLE;
               else if (wdat_last) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      RREQ:    state_nxt = RWAIT;
      RWAIT:   state_nxt = RDATA;
      RDATA:   if (rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sready  = (state == IDLE);
    mem_wen = (state == WRITE);
    mem_ren = (state == RREQ);
    svalid  = (state == RDATA);
    srdata  = (state == RDATA) && tx_q[0];
  end

  // The final bit comes straight from swdata so the word is complete on the same edge as the state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode      <= MODE_READ;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && mvalid) mode <= smode;
      if (addr_last) mem_addr  <= {swdata, rx_q[RXW-1 -: ADDR_WIDTH-1]};
      if (wdat_last) mem_wdata <= {swdata, rx_q[RXW-1 -: DATA_WIDTH-1]};
      if (timeout)
        cnt <= '0;
      else if (rx_shift || state == RDATA)
        cnt <= (addr_last || wdat_last || rd_last) ? '0 : cnt + 1'b1;
    end
  end

  serial_shift_reg #(.WIDTH(RXW)) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (addr_last),
    .load  (1'b0),
    .din   ('0),
    .shift (rx_shift),
    .sin   (swdata),
    .q     (rx_q)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (1'b0),
    .load  (state == RWAIT),
    .din   (mem_rdata),
    .shift (state == RDATA),
    .sin   (1'b0),
    .q     (tx_q)
  );

  assign unused_rx = ^rx_q;
  assign unused_tx = ^tx_q;

endmodule
